// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, byte width and a ceil-log2 helper.
package uart_pkg;

    localparam int unsigned UART_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } uart_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotate-priority search: first set request at or after i_ptr, wrapping at N-1.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [IW-1:0] w_j;

    // Scan from the far end so the closest candidate to i_ptr is assigned last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            w_j = IW'((int'(i_ptr) + k) % int'(N));
            if (i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter feeding a single UART transmitter, one byte per
// transmitter cycle, with a mid-frame idle timeout that drops the grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DW        = UART_DW,
    parameter int unsigned FRAME_TMO = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ*DW-1:0]   i_req_data,
    input  logic [N_REQ-1:0]      i_req_last,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic                  o_tx_start,
    output logic [DW-1:0]         o_tx_data,
    input  logic                  i_tx_busy,
    output logic                  o_grant_active,
    output logic [clog2(N_REQ)-1:0] o_grant_id,
    output logic                  o_frame_abort
);

    localparam int unsigned IW = clog2(N_REQ);
    localparam int unsigned CW = 16;

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_LOAD      = ST_LOAD;
    localparam logic [2:0] S_ISSUE     = ST_ISSUE;
    localparam logic [2:0] S_WAIT_BUSY = ST_WAIT_BUSY;
    localparam logic [2:0] S_WAIT_DONE = ST_WAIT_DONE;

    logic [2:0]    r_state,        w_state_nxt;
    logic [IW-1:0] r_grant_id,     w_grant_id_nxt;
    logic          r_grant_active, w_grant_active_nxt;
    logic          r_tx_start,     w_tx_start_nxt;
    logic [DW-1:0] r_tx_data,      w_tx_data_nxt;
    logic          r_frame_abort,  w_frame_abort_nxt;
    logic [IW-1:0] r_rr_ptr,       w_rr_ptr_nxt;
    logic          r_last_q,       w_last_q_nxt;
    logic [CW-1:0] r_tmo_cnt,      w_tmo_cnt_nxt;

    logic [IW-1:0] w_pick_idx;
    logic          w_pick_found;
    logic [DW-1:0] w_sel_data;
    logic          w_sel_last;
    logic          w_xfer;
    logic [IW-1:0] w_ptr_wrap;

    rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // Byte and last flag of the granted requester.
    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (r_grant_id == IW'(k)) begin
                w_sel_data = i_req_data[k*DW +: DW];
                w_sel_last = i_req_last[k];
            end
        end
    end

    assign w_xfer     = (r_state == S_LOAD) && i_req_valid[r_grant_id];
    assign w_ptr_wrap = (r_grant_id == IW'(N_REQ - 1)) ? '0 : r_grant_id + IW'(1);

    always_comb begin
        o_req_ready = '0;
        if (r_state == S_LOAD) begin
            o_req_ready[r_grant_id] = i_req_valid[r_grant_id];
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_grant_id_nxt     = r_grant_id;
        w_grant_active_nxt = r_grant_active;
        w_tx_start_nxt     = 1'b0;
        w_tx_data_nxt      = r_tx_data;
        w_frame_abort_nxt  = 1'b0;
        w_rr_ptr_nxt       = r_rr_ptr;
        w_last_q_nxt       = r_last_q;
        w_tmo_cnt_nxt      = r_tmo_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_found) begin
                    w_grant_id_nxt     = w_pick_idx;
                    w_grant_active_nxt = 1'b1;
                    w_tmo_cnt_nxt      = '0;
                    w_state_nxt        = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_tx_data_nxt  = w_sel_data;
                    w_tx_start_nxt = 1'b1;
                    w_last_q_nxt   = w_sel_last;
                    w_tmo_cnt_nxt  = '0;
                    w_state_nxt    = S_ISSUE;
                end else if (r_tmo_cnt == CW'(FRAME_TMO - 1)) begin
                    // This idle cycle brings the count to FRAME_TMO.
                    w_frame_abort_nxt  = 1'b1;
                    w_grant_active_nxt = 1'b0;
                    w_rr_ptr_nxt       = w_ptr_wrap;
                    w_tmo_cnt_nxt      = '0;
                    w_state_nxt        = S_IDLE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + CW'(1);
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (r_last_q) begin
                        w_grant_active_nxt = 1'b0;
                        w_rr_ptr_nxt       = w_ptr_wrap;
                        w_state_nxt        = S_IDLE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            default: begin
                w_grant_active_nxt = 1'b0;
                w_state_nxt        = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_grant_id     <= '0;
            r_grant_active <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= '0;
            r_frame_abort  <= 1'b0;
            r_rr_ptr       <= '0;
            r_last_q       <= 1'b0;
            r_tmo_cnt      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant_id     <= w_grant_id_nxt;
            r_grant_active <= w_grant_active_nxt;
            r_tx_start     <= w_tx_start_nxt;
            r_tx_data      <= w_tx_data_nxt;
            r_frame_abort  <= w_frame_abort_nxt;
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_last_q       <= w_last_q_nxt;
            r_tmo_cnt      <= w_tmo_cnt_nxt;
        end
    end

    assign o_tx_start     = r_tx_start;
    assign o_tx_data      = r_tx_data;
    assign o_grant_active = r_grant_active;
    assign o_grant_id     = r_grant_id;
    assign o_frame_abort  = r_frame_abort;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between `N_REQ` byte-stream requesters, such as the command responder, status reporter and debug echo. Requesters hand over bytes on a valid/ready interface grouped into frames delimited by `req_last`. A round-robin arbiter grants one requester at a time and holds the grant for a whole frame. The block sits directly in front of `uart_tx`: it drives `tx_start`/`data_in`, watches `busy`, and issues exactly one byte per transmitter cycle.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `DW`, default 8: byte width; fixed by the UART.
- `FRAME_TMO`, default 1023: idle cycles allowed mid-frame before the grant is forcibly released (1..65535).
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, N_REQ: per-requester byte available.
- `req_data`, in, N_REQ*DW: per-requester byte; requester i owns bits `[i*DW +: DW]`.
- `req_last`, in, N_REQ: byte is the final byte of its frame.
- `req_ready`, out, N_REQ: one-hot accept; a byte transfers when valid & ready.
- `tx_start`, out, 1: one-cycle start pulse to the UART transmitter.
- `tx_data`, out, DW: byte to transmit; stable from the `tx_start` cycle until the next issue.
- `tx_busy`, in, 1: UART transmitter busy flag.
- `grant_active`, out, 1: a frame grant is held.
- `grant_id`, out, clog2(N_REQ): index of the granted requester.
- `frame_abort`, out, 1: one-cycle pulse when the frame timeout fires.

## Operation
- States:
  - **IDLE**: no grant.
  - **LOAD**: grant held, waiting for a byte.
  - **ISSUE**: `tx_start` high.
  - **WAIT_BUSY**: waiting for the UART to accept the byte.
  - **WAIT_DONE**: waiting for the UART to finish the byte.
- **IDLE**
  - If any `req_valid` is high, pick the first valid requester at or after `rr_ptr`, searching upward with wrap from N_REQ-1 to 0.
  - Register `grant_id`, set `grant_active`=1, go to LOAD.
- **LOAD**
  - `req_ready[grant_id]` = `req_valid[grant_id]`, combinational; all other `req_ready` bits are 0.
  - On transfer:
    - `tx_data` <= byte; `tx_start` <= 1.
    - Latch `req_last` into `last_q`; clear the timeout counter.
    - Go to ISSUE.
  - No transfer: the timeout counter increments. When it reaches `FRAME_TMO`:
    - Pulse `frame_abort`, release the grant.
    - `rr_ptr` <= `grant_id`+1 with wrap.
    - Go to IDLE.
- **ISSUE**: lasts one cycle; `tx_start` <= 0; go to WAIT_BUSY.
- **WAIT_BUSY**: on `tx_busy`=1, go to WAIT_DONE. Wait is unbounded.
- **WAIT_DONE**: on `tx_busy`=0:
  - If `last_q`: release the grant, `rr_ptr` <= `grant_id`+1 with wrap, go to IDLE.
  - Else: go to LOAD.
- **Frame lock**: other requesters' `req_valid` is ignored until the grant is released, even if the granted requester stalls.
- **Outside LOAD**: `req_ready` is all zero.
- **Reset values**:
  - `tx_start`=0, `tx_data`=0, `req_ready`=0.
  - `grant_active`=0, `grant_id`=0, `frame_abort`=0.
  - `rr_ptr`=0; timeout counter=0; state IDLE.
- **Reset mid-operation**: everything returns to the reset values immediately. A byte already in the UART completes or is reset by the UART's own reset; the partial frame is dropped.

## Timing
- **First byte**: `req_valid` high in IDLE at cycle 0 → `grant_active` at cycle 1 → `req_ready` pulses in cycle 1 → `tx_start`=1 in cycle 2.
- **Start acceptance**: the UART raises `busy` one edge after sampling `tx_start`, so WAIT_BUSY normally lasts 1 cycle.
- **Back-to-back bytes**: `tx_busy` observed low in cycle t → LOAD in t+1 → `tx_start` in t+2. This holds because the UART is already in IDLE when `busy` falls.
- **Re-arbitration**: after a frame ends, the next grant is taken 1 cycle after returning to IDLE.
- **Timeout**: `frame_abort` asserts in the cycle the counter reaches `FRAME_TMO`, then deasserts.
- **Simultaneous requests**: the lowest index at or after `rr_ptr` wins.

## Structure
- Shared package `uart_pkg` holds:
  - The state enum: IDLE, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE.
  - `UART_DW`=8.
  - The `clog2` helper.
- Sub-module `rr_pick`: combinational rotate-priority search. Inputs are the request vector and the pointer; outputs are the index and `found`. It is reusable by future arbiters.

## Test plan
- **Single frame**: requester 0 sends 3 bytes 0x41, 0x42, 0x43, last on 0x43. Required: 3 `tx_start` pulses with `tx_data` in order, then `grant_active` drops and `rr_ptr`=1.
- **Contention**: requesters 1 and 2 are valid simultaneously with `rr_ptr`=0. Required: requester 1 is granted first, requester 2 after requester 1's last byte.
- **Frame lock**: requester 3 asserts valid mid-frame of requester 0. Required: `req_ready[3]` stays 0 until requester 0's last byte completes.
- **Timeout**: granted requester drops valid mid-frame with `FRAME_TMO`=16. Required: `frame_abort` pulses after 16 LOAD cycles, the grant is released, and no `tx_start` is issued.
- **Wrap**: only requester N_REQ-1 sends a frame, then requester 0. Required: `rr_ptr` wraps to 0 and requester 0 is granted.
- **Reset mid-frame**: assert `rst` during WAIT_DONE. Required: all outputs at reset values the same cycle, and normal operation resumes after deassertion.
